// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if
//   Bundles the request/response and CON-handshake signals of branch_pc_unit.
//   master : control unit / condition logic side (drives requests and con_out)
//   slave  : branch_pc_unit side (drives pc, link_addr, taken, busy, done, con_in)
//
//   start      1         one-cycle operation request
//   op         2         00 INC, 01 BR, 10 JR, 11 JAL
//   offset     C_WIDTH   signed branch displacement
//   jump_addr  PC_WIDTH  JR/JAL target
//   con_out    1         CON flip-flop result
//   con_in     1         CON latch enable
//   pc         PC_WIDTH  program counter
//   link_addr  PC_WIDTH  JAL return address
//   taken      1         last BR outcome
//   busy       1         operation in flight
//   done       1         one-cycle commit pulse
interface branch_pc_unit_if #(
    parameter int PC_WIDTH = 32,
    parameter int C_WIDTH  = 19
);
    logic                start;
    logic [1:0]          op;
    logic [C_WIDTH-1:0]  offset;
    logic [PC_WIDTH-1:0] jump_addr;
    logic                con_out;
    logic                con_in;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] link_addr;
    logic                taken;
    logic                busy;
    logic                done;

    modport master (
        output start, op, offset, jump_addr, con_out,
        input  con_in, pc, link_addr, taken, busy, done
    );

    modport slave (
        input  start, op, offset, jump_addr, con_out,
        output con_in, pc, link_addr, taken, busy, done
    );
endinterface

// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Program-counter and branch-resolution stage. Owns the PC register,
//   performs INC / JR / JAL updates in one cycle and sequences conditional
//   branches through the CON flip-flop (enable pulse, settle, sample, commit).
//
//   clk   in   system clock, rising edge
//   clr   in   synchronous active-high reset
//   bus   slave modport of branch_pc_unit_if (request inputs, CON handshake,
//         pc / link_addr / taken / busy / done outputs)
module branch_pc_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  C_WIDTH  = 19,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             clr,
    branch_pc_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        CON_EVAL,
        CON_SETTLE,
        BR_RESOLVE
    } state_t;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_BR  = 2'b01,
        OP_JR  = 2'b10,
        OP_JAL = 2'b11
    } op_t;

    state_t              state_q, state_d;
    op_t                 op_q;
    logic [C_WIDTH-1:0]  offset_q;
    logic [PC_WIDTH-1:0] jump_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] link_q;
    logic                taken_q;
    logic                done_q;
    logic                con_in_c;
    logic [PC_WIDTH-1:0] offset_ext;

    assign offset_ext = {{(PC_WIDTH-C_WIDTH){offset_q[C_WIDTH-1]}}, offset_q};

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and CON latch enable
    always_comb begin
        state_d  = state_q;
        con_in_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.op == OP_BR) ? CON_EVAL : EXEC;
                end
            end
            EXEC:       state_d = IDLE;
            CON_EVAL: begin
                con_in_c = 1'b1;
                state_d  = CON_SETTLE;
            end
            CON_SETTLE: state_d = BR_RESOLVE;
            BR_RESOLVE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath: operand capture and architectural registers
    always_ff @(posedge clk) begin
        if (clr) begin
            op_q     <= OP_INC;
            offset_q <= '0;
            jump_q   <= '0;
            pc_q     <= RESET_PC;
            link_q   <= '0;
            taken_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= op_t'(bus.op);
                        offset_q <= bus.offset;
                        jump_q   <= bus.jump_addr;
                    end
                end
                EXEC: begin
                    done_q <= 1'b1;
                    case (op_q)
                        OP_INC: pc_q <= pc_q + 1'b1;
                        OP_JR:  pc_q <= jump_q;
                        OP_JAL: begin
                            link_q <= pc_q + 1'b1;
                            pc_q   <= jump_q;
                        end
                        default: ;
                    endcase
                end
                BR_RESOLVE: begin
                    done_q  <= 1'b1;
                    taken_q <= bus.con_out;
                    if (bus.con_out) begin
                        pc_q <= pc_q + offset_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.con_in    = con_in_c;
    assign bus.pc        = pc_q;
    assign bus.link_addr = link_q;
    assign bus.taken     = taken_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit
//   Directed and random operation sequences against a behavioural model of
//   the PC/branch rules; checks cycle-by-cycle handshake and register values.
module tb_branch_pc_unit;

    localparam int PCW = 32;
    localparam int CW  = 19;

    logic clk;
    logic clr;

    branch_pc_unit_if #(.PC_WIDTH(PCW), .C_WIDTH(CW)) bus ();

    branch_pc_unit #(
        .PC_WIDTH(PCW),
        .C_WIDTH (CW),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc;
    logic [31:0] m_link;
    logic        m_taken;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Two's-complement value of a CW-bit field, as an integer displacement
    function automatic logic [31:0] disp(input logic [CW-1:0] v);
        int s;
        s = int'(v);
        if (v >= 19'h40000) s = s - 524288;
        return 32'(s);
    endfunction

    // One full operation, from acceptance to the cycle carrying done.
    task automatic do_op(input logic [1:0] o, input logic [CW-1:0] off,
                         input logic [31:0] ja, input logic cv, input bit inject);
        chk("pre_busy", 32'(bus.busy), 32'd0);
        bus.start     = 1'b1;
        bus.op        = o;
        bus.offset    = off;
        bus.jump_addr = ja;
        bus.con_out   = 1'($urandom);
        tick();
        bus.start     = 1'b0;
        bus.op        = 2'($urandom);
        bus.offset    = 19'($urandom);
        bus.jump_addr = $urandom;
        chk("acc_busy", 32'(bus.busy), 32'd1);
        chk("acc_done", 32'(bus.done), 32'd0);
        if (o == 2'b01) begin
            chk("eval_con_in", 32'(bus.con_in), 32'd1);
            chk("eval_pc", bus.pc, m_pc);
            tick();
            chk("settle_con_in", 32'(bus.con_in), 32'd0);
            chk("settle_busy", 32'(bus.busy), 32'd1);
            bus.con_out = 1'($urandom);
            if (inject) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
            end
            tick();
            bus.start   = 1'b0;
            bus.con_out = cv;
            chk("res_con_in", 32'(bus.con_in), 32'd0);
            chk("res_done", 32'(bus.done), 32'd0);
            chk("res_busy", 32'(bus.busy), 32'd1);
            chk("res_pc", bus.pc, m_pc);
            tick();
            bus.con_out = 1'($urandom);
            m_taken = cv;
            if (cv) m_pc = m_pc + disp(off);
        end else begin
            chk("exec_con_in", 32'(bus.con_in), 32'd0);
            tick();
            case (o)
                2'b00: m_pc = m_pc + 32'd1;
                2'b10: m_pc = ja;
                default: begin
                    m_link = m_pc + 32'd1;
                    m_pc   = ja;
                end
            endcase
        end
        chk("cmt_done", 32'(bus.done), 32'd1);
        chk("cmt_busy", 32'(bus.busy), 32'd0);
        chk("cmt_con_in", 32'(bus.con_in), 32'd0);
        chk("cmt_pc", bus.pc, m_pc);
        chk("cmt_link", bus.link_addr, m_link);
        chk("cmt_taken", 32'(bus.taken), 32'(m_taken));
    endtask

    task automatic idle_chk();
        tick();
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_pc", bus.pc, m_pc);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.offset    = '0;
        bus.jump_addr = '0;
        bus.con_out   = 1'b0;
        clr           = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        m_pc = 32'h0; m_link = 32'h0; m_taken = 1'b0;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_link", bus.link_addr, 32'h0);
        chk("rst_taken", 32'(bus.taken), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_con_in", 32'(bus.con_in), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // Three increments: 0 -> 1 -> 2 -> 3
        for (int i = 0; i < 3; i++) do_op(2'b00, '0, '0, 1'b0, 1'b0);
        chk("inc3_pc", bus.pc, 32'h3);
        idle_chk();

        // Forward taken branch 0x10 + 5
        do_op(2'b10, '0, 32'h10, 1'b0, 1'b0);
        do_op(2'b01, 19'h00005, '0, 1'b1, 1'b0);
        chk("fwd_pc", bus.pc, 32'h15);

        // Backward branch -4 from 0x20: not taken, then taken
        do_op(2'b10, '0, 32'h20, 1'b0, 1'b0);
        do_op(2'b01, 19'h7FFFC, '0, 1'b0, 1'b0);
        chk("nt_pc", bus.pc, 32'h20);
        do_op(2'b01, 19'h7FFFC, '0, 1'b1, 1'b0);
        chk("bwd_pc", bus.pc, 32'h1C);

        // JAL link wrap, then taken branch wrapping past zero
        do_op(2'b10, '0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b11, '0, 32'h100, 1'b0, 1'b0);
        chk("jal_link", bus.link_addr, 32'h0);
        chk("jal_pc", bus.pc, 32'h100);
        do_op(2'b10, '0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op(2'b01, 19'h00003, '0, 1'b1, 1'b0);
        chk("wrap_pc", bus.pc, 32'h1);

        // Start during CON_SETTLE is ignored
        do_op(2'b10, '0, 32'h40, 1'b0, 1'b0);
        do_op(2'b01, 19'h00008, '0, 1'b1, 1'b1);
        idle_chk();
        chk("rej_pc", bus.pc, 32'h48);

        // Reset in CON_SETTLE discards the branch
        bus.start = 1'b1; bus.op = 2'b01; bus.offset = 19'h00010;
        tick();
        bus.start = 1'b0;
        tick();
        bus.con_out = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_pc = 32'h0; m_link = 32'h0; m_taken = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_pc", bus.pc, 32'h0);
        chk("mrst_con_in", 32'(bus.con_in), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_taken", 32'(bus.taken), 32'd0);
        chk("mrst_link", bus.link_addr, 32'h0);
        idle_chk();
        do_op(2'b00, '0, '0, 1'b0, 1'b0);
        chk("mrst_inc_pc", bus.pc, 32'h1);

        // Random operation mix
        for (int i = 0; i < 300; i++) begin
            do_op(2'($urandom_range(0, 3)), 19'($urandom), $urandom,
                  1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle_chk();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
